// File: rtl/alu_multicycle_if.sv
// Execute-stage handshake bundle between the datapath controller (master) and alu_multicycle (slave).
interface alu_multicycle_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start_i;
  logic [3:0]             alu_operation_i;
  logic [DATA_WIDTH-1:0]  a_i;
  logic [DATA_WIDTH-1:0]  b_i;
  logic [SHAMT_WIDTH-1:0] shamt_i;
  logic [DATA_WIDTH-1:0]  result_o;
  logic                   zero_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   invalid_o;
  logic                   overflow_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i, shamt_i,
    input  result_o, zero_o, busy_o, done_o, invalid_o, overflow_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i, shamt_i,
    output result_o, zero_o, busy_o, done_o, invalid_o, overflow_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle execute stage: single-cycle logic/arithmetic, bit-serial shifts, start/done handshake.
// Optional signed ADD/SUB overflow flag enabled by defining ALU_MULTICYCLE_OVERFLOW_EN.
module alu_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic              clk,
  input logic              reset,
  alu_multicycle_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_ANDI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL);
  endfunction

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_ORI, OP_SRL, OP_SLL,
      OP_LUI, OP_ANDI, OP_LW, OP_SW, OP_NOR, OP_AND: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){1'b0}}, v};
  endfunction

  // Shift ops only reach here with shamt==0, where the result is B unchanged.
  function automatic logic [DATA_WIDTH-1:0] alu_eval(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    case (op)
      OP_ADD, OP_LW, OP_SW: return a + b;
      OP_SUB:               return a - b;
      OP_OR:                return a | b;
      OP_ORI:               return a | zext16(b[15:0]);
      OP_ANDI:              return a & zext16(b[15:0]);
      OP_AND:               return a & b;
      OP_NOR:               return ~(a | b);
      OP_LUI:               return zext16(b[15:0]) << 16;
      OP_SRL, OP_SLL:       return b;
      default:              return '0;
    endcase
  endfunction

  state_t                 state;
  state_t                 state_nxt;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  sreg;
  logic                   shift_left;
  logic [DATA_WIDTH-1:0]  shift_step;
  logic [DATA_WIDTH-1:0]  result;
  logic                   zero;
  logic                   invalid;
  logic                   accept;
  logic                   shift_start;
  logic                   shift_last;
  logic [DATA_WIDTH-1:0]  eval_res;

  assign accept      = (state == IDLE) && bus.start_i;
  assign shift_start = is_shift(bus.alu_operation_i) && (bus.shamt_i != '0);
  assign shift_last  = (state == SHIFT) && (cnt == SHAMT_WIDTH'(1));
  assign eval_res    = alu_eval(bus.alu_operation_i, bus.a_i, bus.b_i);
  assign shift_step  = shift_left ? {sreg[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg[DATA_WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt = shift_start ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_WIDTH'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and architectural outputs; reset clears everything so an aborted op leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (shift_start) begin
          cnt <= bus.shamt_i;
        end else begin
          result  <= eval_res;
          zero    <= (eval_res == '0);
          invalid <= !op_supported(bus.alu_operation_i);
        end
      end else if (state == SHIFT) begin
        cnt <= cnt - SHAMT_WIDTH'(1);
        if (shift_last) begin
          result  <= shift_step;
          zero    <= (shift_step == '0);
          invalid <= 1'b0;
        end
      end
    end
  end

  // Shift datapath: loaded on accept, stepped once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (accept && shift_start) begin
      sreg       <= bus.b_i;
      shift_left <= (bus.alu_operation_i == OP_SLL);
    end else if (state == SHIFT) begin
      sreg <= shift_step;
    end
  end

`ifdef ALU_MULTICYCLE_OVERFLOW_EN
  function automatic logic add_sub_ovf(
    input logic [3:0]                   op,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH-1:0] r;
    case (op)
      OP_ADD: begin
        r = a + b;
        return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        r = a - b;
        return (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      default: return 1'b0;
    endcase
  endfunction

  logic overflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (accept && !shift_start) begin
      overflow <= add_sub_ovf(bus.alu_operation_i, bus.a_i, bus.b_i);
    end else if (shift_last) begin
      overflow <= 1'b0;
    end
  end

  assign bus.overflow_o = overflow;
`else
  assign bus.overflow_o = 1'b0;
`endif

  assign bus.result_o  = result;
  assign bus.zero_o    = zero;
  assign bus.invalid_o = invalid;
  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = (state == DONE);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with a result scoreboard checked on every done_o pulse.
module tb_alu_multicycle;

`ifdef ALU_MULTICYCLE_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
    logic        inv;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   ncmp;
  int   nerr;
  int   lat;
  exp_t sb_q[$];

  alu_multicycle_if bus ();

  alu_multicycle dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.done_o) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'(bus.done_o), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.tag, ".result"},   bus.result_o,          e.res);
        chk({e.tag, ".zero"},     32'(bus.zero_o),       32'(e.zero));
        chk({e.tag, ".invalid"},  32'(bus.invalid_o),    32'(e.inv));
        chk({e.tag, ".overflow"}, 32'(bus.overflow_o),   32'(e.ovf));
        chk({e.tag, ".busy"},     32'(bus.busy_o),       32'd1);
      end
    end
  end

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                        input logic ei, input logic eo, input int elat);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.alu_operation_i = op;
    bus.a_i             = a;
    bus.b_i             = b;
    bus.shamt_i         = sh;
    e.tag = tag; e.res = er; e.zero = (er == 32'd0); e.inv = ei; e.ovf = eo;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start_i         = 1'b0;
    bus.a_i             = $urandom;
    bus.b_i             = $urandom;
    bus.alu_operation_i = 4'($urandom);
    bus.shamt_i         = 5'($urandom);
    n = 0;
    while (!bus.done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(elat));
    @(posedge clk); #1;
    chk({tag, ".done_drop"}, 32'(bus.done_o), 32'd0);
    chk({tag, ".idle"},      32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;

    // Reset held with a pending start request.
    reset               = 1'b0;
    bus.start_i         = 1'b1;
    bus.alu_operation_i = 4'b0000;
    bus.a_i             = $urandom;
    bus.b_i             = $urandom;
    bus.shamt_i         = 5'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.result",   bus.result_o,          32'd0);
    chk("rst.zero",     32'(bus.zero_o),       32'd0);
    chk("rst.busy",     32'(bus.busy_o),       32'd0);
    chk("rst.done",     32'(bus.done_o),       32'd0);
    chk("rst.invalid",  32'(bus.invalid_o),    32'd0);
    chk("rst.overflow", 32'(bus.overflow_o),   32'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    chk("rel.done", 32'(bus.done_o), 32'd0);
    chk("rel.busy", 32'(bus.busy_o), 32'd0);

    run_op("add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, OVF_EN, 0);
    run_op("sub_zero", 4'b0001, 32'h1234_5678, 32'h1234_5678, 5'd0,  32'h0000_0000, 1'b0, 1'b0,   0);
    run_op("sub_ovf",  4'b0001, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, OVF_EN, 0);
    run_op("lw_add",   4'b1000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b0,   0);
    run_op("sll31",    4'b0101, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0,   31);
    run_op("sll0",     4'b0101, 32'hFFFF_FFFF, 32'h0000_00A5, 5'd0,  32'h0000_00A5, 1'b0, 1'b0,   0);
    run_op("ori",      4'b0011, 32'hF000_0000, 32'hFFFF_1234, 5'd0,  32'hF000_1234, 1'b0, 1'b0,   0);
    run_op("andi",     4'b0111, 32'hFFFF_FFFF, 32'h1234_00F0, 5'd0,  32'h0000_00F0, 1'b0, 1'b0,   0);
    run_op("nor",      4'b1100, 32'hF0F0_0000, 32'h0F0F_0000, 5'd0,  32'h0000_FFFF, 1'b0, 1'b0,   0);
    run_op("and",      4'b1101, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0,  32'h0F00_0F00, 1'b0, 1'b0,   0);
    run_op("or",       4'b0010, 32'hA000_0005, 32'h0500_0A00, 5'd0,  32'hA500_0A05, 1'b0, 1'b0,   0);

    // SRL with start and operand disturbance while shifting and in the done cycle.
    begin
      exp_t e;
      @(negedge clk);
      bus.start_i         = 1'b1;
      bus.alu_operation_i = 4'b0100;
      bus.b_i             = 32'hF000_0000;
      bus.shamt_i         = 5'd4;
      e.tag = "srl_dist"; e.res = 32'h0F00_0000; e.zero = 1'b0; e.inv = 1'b0; e.ovf = 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      lat = 0;
      while (!bus.done_o && lat < 100) begin
        bus.start_i         = ~bus.start_i;
        bus.b_i             = $urandom;
        bus.alu_operation_i = 4'b0000;
        bus.shamt_i         = 5'($urandom);
        @(posedge clk); #1;
        lat++;
      end
      chk("srl_dist.latency", 32'(lat), 32'd4);
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        chk("srl_dist.no_restart", 32'(bus.busy_o), 32'd0);
      end
    end

    // Repeat of the SRL aborted by reset during the second shift cycle.
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.alu_operation_i = 4'b0100;
    bus.b_i             = 32'hF000_0000;
    bus.shamt_i         = 5'd4;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort.result", bus.result_o,        32'd0);
    chk("abort.busy",   32'(bus.busy_o),     32'd0);
    chk("abort.done",   32'(bus.done_o),     32'd0);
    chk("abort.zero",   32'(bus.zero_o),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort.quiet", 32'(bus.done_o | bus.busy_o), 32'd0);
    end

    run_op("inv_1111", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("lui",      4'b0110, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 0);
    run_op("inv_1010", 4'b1010, 32'h0000_0001, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("srl_full", 4'b0100, 32'h0000_0000, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 31);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
